// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state, frame-format encodings and default divisor derivation for the UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_e;

    typedef enum logic [1:0] {
        DB_5 = 2'b00,
        DB_6 = 2'b01,
        DB_7 = 2'b10,
        DB_8 = 2'b11
    } data_bits_e;

    function automatic longint unsigned def_div(input longint unsigned clk_freq, input longint unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; pushes while full and pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full    = level_q == (AW+1)'(DEPTH);
    assign empty   = level_q == '0;
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_q];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with per-frame data length, parity, stop bits and bit period.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 184333000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int          FIFO_DEPTH = 16,
    parameter int          DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [1:0]                    cfg_data_bits,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    input  logic [DIV_WIDTH-1:0]          cfg_div,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam longint unsigned DEF_DIV = def_div(CLK_FREQ, BAUD_RATE);
    localparam logic [DIV_WIDTH:0] ONE = 1;

    if (DEF_DIV == 0 || DEF_DIV >= (64'd1 << DIV_WIDTH)) begin : g_div_chk
        $error("DEF_DIV does not fit DIV_WIDTH");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
        $error("FIFO_DEPTH must be a power of 2 and at least 2");
    end

    state_e               state_q;
    parity_e              parity_q;
    logic [1:0]           db_q;
    logic                 stop2_q, par_q, tx_q, busy_q;
    logic [DIV_WIDTH-1:0] div_q, eff_div;
    logic [DIV_WIDTH:0]   cnt_q, stop_len;
    logic [2:0]           bit_q;
    logic [7:0]           sh_q, fifo_dout;
    logic                 fifo_full, fifo_empty, push, pop;
    logic                 bit_end, stop_end, par_en;

    assign eff_div  = cfg_div == '0 ? DIV_WIDTH'(DEF_DIV) : (cfg_div == DIV_WIDTH'(1) ? DIV_WIDTH'(2) : cfg_div);
    assign s_ready  = ~fifo_full & ~rst;
    assign push     = s_valid & s_ready;
    assign stop_len = stop2_q ? {div_q, 1'b0} : {1'b0, div_q};
    assign bit_end  = cnt_q == {1'b0, div_q} - ONE;
    assign stop_end = cnt_q == stop_len - ONE;
    assign par_en   = parity_q == PAR_EVEN || parity_q == PAR_ODD;
    // Popping at the last stop cycle chains the next frame with no idle cycle.
    assign pop      = ~fifo_empty & (state_q == ST_IDLE || (state_q == ST_STOP && stop_end));
    assign tx       = tx_q;
    assign busy     = busy_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (s_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            div_q    <= '0;
            db_q     <= '0;
            parity_q <= PAR_NONE;
            stop2_q  <= 1'b0;
        end else if (pop) begin
            state_q  <= ST_START;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            bit_q    <= '0;
            sh_q     <= fifo_dout;
            par_q    <= 1'b0;
            div_q    <= eff_div;
            db_q     <= cfg_data_bits;
            parity_q <= parity_e'(cfg_parity);
            stop2_q  <= cfg_stop2;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= push;
                end
                ST_START: begin
                    cnt_q <= bit_end ? '0 : cnt_q + ONE;
                    if (bit_end) begin
                        state_q <= ST_DATA;
                        tx_q    <= sh_q[0];
                    end
                end
                ST_DATA: begin
                    cnt_q <= bit_end ? '0 : cnt_q + ONE;
                    if (bit_end) begin
                        sh_q  <= sh_q >> 1;
                        par_q <= par_q ^ sh_q[0];
                        bit_q <= bit_q + 3'd1;
                        // Last data bit index is data length minus one: {1, cfg_data_bits}.
                        if (bit_q == {1'b1, db_q}) begin
                            state_q <= par_en ? ST_PARITY : ST_STOP;
                            tx_q    <= par_en ? (par_q ^ sh_q[0] ^ (parity_q == PAR_ODD)) : 1'b1;
                        end else begin
                            tx_q <= sh_q[1];
                        end
                    end
                end
                ST_PARITY: begin
                    cnt_q <= bit_end ? '0 : cnt_q + ONE;
                    if (bit_end) begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    cnt_q <= stop_end ? '0 : cnt_q + ONE;
                    if (stop_end) begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                        busy_q  <= push;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                    busy_q  <= ~fifo_empty | push;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a frame scoreboard checked bit-by-bit against the serial line.
module tb_uart_tx_fifo;
    localparam int DEF_DIV = 184333000 / 115200;

    typedef struct {
        logic [7:0] data;
        logic [1:0] db;
        logic [1:0] par;
        logic       stop2;
        int         div;
        bit         b2b;
    } item_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0, s_ready;
    logic [1:0]  cfg_data_bits = 2'b11, cfg_parity = 2'b00;
    logic        cfg_stop2 = 1'b0;
    logic [15:0] cfg_div = 16'd16;
    logic        tx, busy;
    logic [4:0]  fifo_level;

    int    cyc = 0, errors = 0, checks = 0;
    int    peak = 0, acc_cnt = 0, stall_acc = -1;
    bit    track = 1'b0;
    item_t sb[$];

    uart_tx_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .cfg_div       (cfg_div),
        .tx            (tx),
        .busy          (busy),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) peak = !track ? 0 : (int'(fifo_level) > peak ? int'(fifo_level) : peak);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic item_t mk(input logic [7:0] d, input bit b2b);
        item_t it;
        it.data  = d;
        it.db    = cfg_data_bits;
        it.par   = cfg_parity;
        it.stop2 = cfg_stop2;
        it.div   = cfg_div == 16'd0 ? DEF_DIV : (cfg_div == 16'd1 ? 2 : int'(cfg_div));
        it.b2b   = b2b;
        return it;
    endfunction

    task automatic push(input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && t < 5000) begin
            if (stall_acc < 0) stall_acc = acc_cnt;
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            chk("push_accept", s_ready, 1);
            s_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        acc_cnt++;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((busy !== 1'b0 || sb.size() != 0) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, " busy_low"}, busy, 0);
        chk({tag, " tx_idle"}, tx, 1);
        chk({tag, " level_zero"}, fifo_level, 0);
    endtask

    // Scoreboard consumer: checks every cycle of every expected frame.
    initial begin : monitor
        item_t       it;
        logic [11:0] seq;
        int          t, n, mism, last_end;
        logic        p;
        last_end = -100;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                it = sb[0];
                t  = 0;
                while (tx !== 1'b0 && t < 3000) begin
                    @(negedge clk);
                    t++;
                end
                chk($sformatf("start_seen %02h", it.data), tx, 0);
                if (it.b2b) chk($sformatf("no_gap %02h", it.data), cyc, last_end + 1);
                seq = '1;
                seq[0] = 1'b0;
                n = 1;
                p = (it.par == 2'b10);
                for (int i = 0; i < 5 + it.db; i++) begin
                    seq[n] = it.data[i];
                    p ^= it.data[i];
                    n++;
                end
                if (it.par == 2'b01 || it.par == 2'b10) begin
                    seq[n] = p;
                    n++;
                end
                n += it.stop2 ? 2 : 1;
                for (int b = 0; b < n; b++) begin
                    mism = 0;
                    for (int c = 0; c < it.div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (tx !== seq[b]) mism++;
                    end
                    chk($sformatf("frame %02h bit%0d bad_cycles", it.data, b), mism, 0);
                end
                last_end = cyc;
                void'(sb.pop_front());
            end
        end
    end

    initial begin : stimulus
        int    p, t;
        item_t it_b;
        repeat (3) @(negedge clk);
        chk("rst tx", tx, 1);
        chk("rst busy", busy, 0);
        chk("rst level", fifo_level, 0);
        chk("rst s_ready", s_ready, 0);
        rst = 1'b0;
        #1 chk("s_ready after rst", s_ready, 1);

        cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_div = 16'd16;
        push(8'h55);
        p = cyc;
        sb.push_back(mk(8'h55, 1'b0));
        @(negedge clk);
        chk("latency tx idle N+1", tx, 1);
        @(negedge clk);
        chk("latency tx low N+2", tx, 0);
        chk("busy in frame", busy, 1);
        t = 0;
        while (busy && t < 1000) begin
            @(negedge clk);
            t++;
        end
        chk("busy fall cycle", cyc - p, 161);
        wait_idle("8N1");

        cfg_parity = 2'b01; cfg_div = 16'd4;
        push(8'h07);
        sb.push_back(mk(8'h07, 1'b0));
        wait_idle("8E1");
        cfg_parity = 2'b10;
        push(8'h07);
        sb.push_back(mk(8'h07, 1'b0));
        wait_idle("8O1");

        cfg_data_bits = 2'b10; cfg_parity = 2'b10; cfg_stop2 = 1'b1; cfg_div = 16'd8;
        push(8'h41);
        sb.push_back(mk(8'h41, 1'b0));
        wait_idle("7O2");

        cfg_data_bits = 2'b00; cfg_parity = 2'b01; cfg_stop2 = 1'b1; cfg_div = 16'd1;
        push(8'h13);
        sb.push_back(mk(8'h13, 1'b0));
        wait_idle("5E2 div clamp");

        cfg_data_bits = 2'b11; cfg_parity = 2'b11; cfg_stop2 = 1'b0; cfg_div = 16'd0;
        push(8'hC3);
        sb.push_back(mk(8'hC3, 1'b0));
        wait_idle("default div");

        cfg_parity = 2'b00; cfg_div = 16'd2;
        push(8'hF0);
        sb.push_back(mk(8'hF0, 1'b0));
        acc_cnt = 0; stall_acc = -1; track = 1'b1;
        for (int i = 0; i < 17; i++) begin
            push(8'h10 + 8'(i));
            sb.push_back(mk(8'h10 + 8'(i), 1'b1));
        end
        chk("accepted before stall", stall_acc, 16);
        wait_idle("burst");
        chk("peak level", peak, 16);
        track = 1'b0;

        cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_div = 16'd4;
        push(8'hA5);
        sb.push_back(mk(8'hA5, 1'b0));
        push(8'h3C);
        it_b = '{8'h3C, 2'b10, 2'b10, 1'b1, 6, 1'b1};
        sb.push_back(it_b);
        repeat (10) @(negedge clk);
        cfg_data_bits = 2'b10; cfg_parity = 2'b10; cfg_stop2 = 1'b1; cfg_div = 16'd6;
        wait_idle("cfg change");

        cfg_data_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0; cfg_div = 16'd4;
        push(8'h11);
        p = cyc;
        push(8'h22);
        chk("level before rst", fifo_level, 1);
        while (cyc < p + 30) @(negedge clk);
        chk("tx mid-frame data bit", tx, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst tx", tx, 1);
        chk("mid rst level", fifo_level, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst s_ready", s_ready, 0);
        rst = 1'b0;
        #1 chk("s_ready after mid rst", s_ready, 1);
        repeat (6) @(negedge clk);
        chk("no frame after rst tx", tx, 1);
        chk("no frame after rst busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 184333000, giving the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, used to derive DEF_DIV = CLK_FREQ/BAUD_RATE.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, a power of 2 and at least 2.
REQ-004 The block SHALL have parameter DIV_WIDTH, default 16, the width of the bit-period divisor.
REQ-005 clk  in  1  system clock; all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 s_data  in  8  byte to enqueue, LSB transmitted first.
REQ-008 s_valid / s_ready  in / out  1 / 1  enqueue handshake; transfer occurs when both are high.
REQ-009 cfg_data_bits  in  2  frame data length: 00=5, 01=6, 10=7, 11=8.
REQ-010 cfg_parity  in  2  parity mode: 00=none, 01=even, 10=odd, 11=none.
REQ-011 cfg_stop2  in  1  stop bits: 0=one stop bit, 1=two stop bits.
REQ-012 cfg_div  in  DIV_WIDTH  bit period in clk cycles: 0 selects DEF_DIV; 1 is clamped to 2.
REQ-013 tx  out  1  serial line, idle high.
REQ-014 busy  out  1  high while a frame is in flight or the FIFO is non-empty.
REQ-015 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.

Function
REQ-016 s_ready SHALL equal NOT full, registered-state based; a push while full SHALL NOT occur and SHALL NOT corrupt the FIFO.
REQ-017 A push and a pop in the same cycle SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte, latch cfg_* and the effective divisor, and enter START on the next cycle.
REQ-020 Latency: a push at cycle N into an empty FIFO, with the FSM in IDLE, SHALL drive tx low from cycle N+2.
REQ-021 Each bit SHALL last exactly the latched divisor D cycles, counted 0..D-1.
REQ-022 START SHALL drive tx=0 for D cycles, then go to DATA.
REQ-023 DATA SHALL shift out LSB first for the latched 5..8 bits, then go to PARITY if parity is enabled, otherwise to STOP.
REQ-024 PARITY SHALL drive the XOR of the transmitted data bits for even parity, or its inverse for odd parity; upper unsent bits SHALL be excluded.
REQ-025 STOP SHALL drive tx=1 for D cycles, or 2D cycles when two stop bits are latched.
REQ-026 On the last cycle of STOP with the FIFO non-empty, the FSM SHALL pop and re-latch config, and enter START with no idle cycle; otherwise it SHALL go to IDLE.
REQ-027 Changes to cfg_* during a frame SHALL NOT affect that frame.
REQ-028 The bit counter SHALL count D-1 and the divisor arithmetic SHALL be unsigned; DEF_DIV SHALL fit DIV_WIDTH, enforced by an elaboration check.
REQ-029 busy SHALL be registered; it SHALL fall in the cycle after the final stop bit ends with the FIFO empty.
REQ-030 Unused or illegal FSM encodings SHALL recover to IDLE with tx=1.

Reset
REQ-031 While rst is high: tx=1, busy=0, fifo_level=0, s_ready=0, FSM=IDLE, counters=0, FIFO pointers=0.
REQ-032 s_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-033 Reset mid-frame SHALL abort the frame, return tx high in the next cycle, and discard FIFO contents.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state enum, the parity and data-bits encodings, and the DEF_DIV derivation.
REQ-035 The FIFO SHALL be a sub-module sync_fifo (parameters WIDTH, DEPTH) with push/pop/full/empty/level ports.

Verification
REQ-036 0x55, 8N1, cfg_div=16 -> tx start 0, then 1,0,1,0,1,0,1,0, then stop 1; 160 cycles total; busy drops at cycle 161.
REQ-037 0x07, 8E1, cfg_div=4 -> parity bit 1, frame of 11 bits = 44 cycles; 8O1 with the same byte -> parity bit 0.
REQ-038 0x41, 7O2, cfg_div=8 -> data 1,0,0,0,0,0,1, parity 1, two stop bits; frame of 11 bits = 88 cycles.
REQ-039 17 back-to-back pushes with cfg_div=2 -> s_ready low after 16 accepted; all 17 bytes sent in order with no idle gap; fifo_level peaks at 16.
REQ-040 Assert rst at cycle 30 of a frame, and change cfg mid-frame in a separate run -> on reset, tx=1 and fifo_level=0 next cycle; on cfg change, the current frame is unchanged and the next frame uses the new cfg.
